// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one request/acknowledge memory channel.
//
// Handshake: the requester raises rq with rw/adr/dw and holds all four stable
// until it sees ak. ak is a single-cycle pulse; err and dr are valid only
// while ak is high. rq still high in the cycle after ak is a new request.
//
// Signals:
//   rq   request level (requester -> responder)
//   rw   direction, 1 = write, 0 = read
//   adr  20-bit word address
//   dw   16-bit write data
//   ak   one-cycle acknowledge (responder -> requester)
//   err  error flag, valid with ak
//   dr   16-bit read data, valid with ak
//
// Modports: master = requester side, slave = responder side.
interface mem_arbiter_if;
  logic        rq;
  logic        rw;
  logic [19:0] adr;
  logic [15:0] dw;
  logic        ak;
  logic        err;
  logic [15:0] dr;

  modport master (output rq, rw, adr, dw, input ak, err, dr);
  modport slave  (input rq, rw, adr, dw, output ak, err, dr);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory channel between the fetch unit (f)
// and the execute unit (x). One transaction is in flight at a time. X has
// priority; after MAXX consecutive X grants with F waiting, F is served next.
// A watchdog aborts a downstream access not acknowledged within TMO cycles
// (TMO = 0 disables it) and returns err = 1, dr = 16'hFFFF.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   f          fetch channel (slave side)
//   x          execute channel (slave side)
//   mem        downstream channel (master side); rq/rw/adr/dw are registered
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module mem_arbiter #(
  parameter int unsigned MAXX = 4,
  parameter int unsigned TMO  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.slave         f,
  mem_arbiter_if.slave         x,
  mem_arbiter_if.master        mem,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MAXX4   = 4'(MAXX);
  localparam logic [7:0] TMO_M1  = 8'(TMO - 1);
  localparam bit         WDOG_EN = (TMO != 0);

  state_t      state_q, state_d;
  logic        owner_x_q;   // 1: current transaction belongs to x
  logic [3:0]  xcnt_q;      // consecutive x grants while f was waiting
  logic [7:0]  wcnt_q;      // cycles spent in BUSY without mem.ak
  logic        err_q;       // last completion was a watchdog abort
  logic        rq_q;
  logic        rw_q;
  logic [19:0] adr_q;
  logic [15:0] dw_q;
  logic [15:0] f_dr_q;
  logic [15:0] x_dr_q;

  logic        grant_x;
  logic        grant_f;
  logic        tmo_hit;

  // x wins unless f is waiting and x has already used its quota.
  assign grant_x = x.rq && (!f.rq || (xcnt_q < MAXX4));
  assign grant_f = !grant_x && f.rq;
  assign tmo_hit = WDOG_EN && (wcnt_q == TMO_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_x || grant_f) state_d = BUSY;
      BUSY:    if (mem.ak || tmo_hit)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_x_q <= 1'b0;
      xcnt_q    <= 4'd0;
      wcnt_q    <= 8'd0;
      err_q     <= 1'b0;
      rq_q      <= 1'b0;
      rw_q      <= 1'b0;
      adr_q     <= 20'd0;
      dw_q      <= 16'd0;
      f_dr_q    <= 16'd0;
      x_dr_q    <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_x || grant_f) begin
            owner_x_q <= grant_x;
            rq_q      <= 1'b1;
            rw_q      <= grant_x ? x.rw  : f.rw;
            adr_q     <= grant_x ? x.adr : f.adr;
            dw_q      <= grant_x ? x.dw  : f.dw;
            wcnt_q    <= 8'd0;
            // Only x grants that bypass a waiting f count toward starvation.
            if (grant_x && f.rq) begin
              if (xcnt_q != 4'hF) xcnt_q <= xcnt_q + 4'd1;
            end else begin
              xcnt_q <= 4'd0;
            end
          end
        end
        BUSY: begin
          if (mem.ak) begin
            rq_q  <= 1'b0;
            err_q <= 1'b0;
            if (owner_x_q) x_dr_q <= mem.dr;
            else           f_dr_q <= mem.dr;
          end else if (tmo_hit) begin
            rq_q  <= 1'b0;
            err_q <= 1'b1;
            if (owner_x_q) x_dr_q <= 16'hFFFF;
            else           f_dr_q <= 16'hFFFF;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Acknowledges decode straight from RESP so exactly one requester sees a
  // single-cycle pulse; err is gated so it can never accompany a normal ack.
  assign f.ak  = (state_q == RESP) && !owner_x_q;
  assign x.ak  = (state_q == RESP) &&  owner_x_q;
  assign f.err = f.ak && err_q;
  assign x.err = x.ak && err_q;
  assign f.dr  = f_dr_q;
  assign x.dr  = x_dr_q;

  assign mem.rq  = rq_q;
  assign mem.rw  = rw_q;
  assign mem.adr = adr_q;
  assign mem.dw  = dw_q;

  assign dbg_state = state_q;

endmodule
